// File: rtl/shift_arbiter.sv
// Two-port round-robin front end for one 16-bit barrel shifter, with a
// one-entry response buffer tagged by requester id and illegal-op flag.

module shift_arbiter_shifter (
    input  logic [15:0] in_i,
    input  logic [3:0]  shamt_i,
    input  logic [1:0]  select_i,
    output logic [15:0] out_o
);
    always_comb begin
        out_o = 16'h0000;
        unique case (select_i)
            2'b11:   out_o = in_i << shamt_i;
            2'b00:   out_o = in_i >> shamt_i;
            2'b01:   out_o = $signed(in_i) >>> shamt_i;
            default: out_o = 16'h0000;
        endcase
    end
endmodule

module shift_arbiter #(
    parameter bit PRIORITY_INIT = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [15:0] req0_in_i,
    input  logic [3:0]  req0_shamt_i,
    input  logic [1:0]  req0_select_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [15:0] req1_in_i,
    input  logic [3:0]  req1_shamt_i,
    input  logic [1:0]  req1_select_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [15:0] resp_data_o,
    output logic        resp_id_o,
    output logic        resp_err_o
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] data_q, data_d;
    logic        id_q, id_d;
    logic        err_q, err_d;
    logic        last_q, last_d;

    logic        slot, grant0, grant1, accept, sel_id;
    logic [15:0] sh_in, sh_out;
    logic [3:0]  sh_amt;
    logic [1:0]  sh_sel;

    // On contention the port that was not served last wins.
    assign grant0 = req0_valid_i & (~req1_valid_i | last_q);
    assign grant1 = req1_valid_i & (~req0_valid_i | ~last_q);
    assign slot   = ~resp_valid_o | resp_ready_i;

    assign req0_ready_o = grant0 & slot & ~rst_i;
    assign req1_ready_o = grant1 & slot & ~rst_i;
    assign accept       = (req0_valid_i & req0_ready_o) | (req1_valid_i & req1_ready_o);
    assign sel_id       = grant1;

    assign sh_in  = sel_id ? req1_in_i     : req0_in_i;
    assign sh_amt = sel_id ? req1_shamt_i  : req0_shamt_i;
    assign sh_sel = sel_id ? req1_select_i : req0_select_i;

    shift_arbiter_shifter u_shifter (
        .in_i     (sh_in),
        .shamt_i  (sh_amt),
        .select_i (sh_sel),
        .out_o    (sh_out)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;
        last_d  = last_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (resp_ready_i && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            err_d  = (sh_sel == 2'b10);
            data_d = (sh_sel == 2'b10) ? 16'h0000 : sh_out;
            id_d   = sel_id;
            last_d = sel_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            data_q  <= 16'h0000;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= ~PRIORITY_INIT;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign resp_valid_o = (state_q == FULL);
    assign resp_data_o  = data_q;
    assign resp_id_o    = id_q;
    assign resp_err_o   = err_q;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed-vector bench for shift_arbiter: arbitration order, shift ops,
// backpressure, illegal op and mid-operation reset.

module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        v0, r0, v1, r1;
    logic [15:0] in0, in1;
    logic [3:0]  sh0, sh1;
    logic [1:0]  se0, se1;
    logic        rv, rr, rid, rerr;
    logic [15:0] rdata;
    int          n_run  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.PRIORITY_INIT(1'b0)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v0), .req0_ready_o(r0), .req0_in_i(in0),
        .req0_shamt_i(sh0), .req0_select_i(se0),
        .req1_valid_i(v1), .req1_ready_o(r1), .req1_in_i(in1),
        .req1_shamt_i(sh1), .req1_select_i(se1),
        .resp_valid_o(rv), .resp_ready_i(rr), .resp_data_o(rdata),
        .resp_id_o(rid), .resp_err_o(rerr)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rr = 1'b1;
        v0 = 1'b1; in0 = 16'h0; sh0 = 4'd0; se0 = 2'b11;
        v1 = 1'b0; in1 = 16'h0; sh1 = 4'd0; se1 = 2'b11;
        step(); step();
        chk("rst_valid", {15'd0, rv}, 16'd0);
        chk("rst_data", rdata, 16'h0000);
        chk("rst_id", {15'd0, rid}, 16'd0);
        chk("rst_err", {15'd0, rerr}, 16'd0);
        chk("rst_ready0", {15'd0, r0}, 16'd0);

        // 1: single LSL on port 0
        rst = 1'b0; in0 = 16'h8001; sh0 = 4'd1; se0 = 2'b11;
        #1;
        chk("t1_ready0", {15'd0, r0}, 16'd1);
        chk("t1_ready1", {15'd0, r1}, 16'd0);
        step();
        v0 = 1'b0;
        chk("t1_valid", {15'd0, rv}, 16'd1);
        chk("t1_data", rdata, 16'h0002);
        chk("t1_id", {15'd0, rid}, 16'd0);
        chk("t1_err", {15'd0, rerr}, 16'd0);

        // 2: ASR vs LSR, shamt 0 passthrough on port 1
        v1 = 1'b1; in1 = 16'hF000; sh1 = 4'd4; se1 = 2'b01;
        step();
        chk("t2_asr", rdata, 16'hFF00);
        chk("t2_id", {15'd0, rid}, 16'd1);
        se1 = 2'b00;
        step();
        chk("t2_lsr", rdata, 16'h0F00);
        in1 = 16'h7FF0; sh1 = 4'd0; se1 = 2'b01;
        step();
        chk("t2_sh0", rdata, 16'h7FF0);
        v1 = 1'b0;
        step();
        chk("t2_drain_valid", {15'd0, rv}, 16'd0);
        chk("t2_drain_data", rdata, 16'h7FF0);

        // 3: both valid, alternate 0,1,0,1 (port 1 served last)
        v0 = 1'b1; in0 = 16'h0001; sh0 = 4'd1; se0 = 2'b11;
        v1 = 1'b1; in1 = 16'h0100; sh1 = 4'd1; se1 = 2'b00;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_ready0", {15'd0, r0}, (i % 2 == 0) ? 16'd1 : 16'd0);
            chk("t3_ready1", {15'd0, r1}, (i % 2 == 0) ? 16'd0 : 16'd1);
            step();
            chk("t3_valid", {15'd0, rv}, 16'd1);
            chk("t3_id", {15'd0, rid}, (i % 2 == 0) ? 16'd0 : 16'd1);
            chk("t3_data", rdata, (i % 2 == 0) ? 16'h0002 : 16'h0080);
        end

        // 4: backpressure for 5 cycles, then same-cycle refill
        rr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_ready0", {15'd0, r0}, 16'd0);
            chk("t4_ready1", {15'd0, r1}, 16'd0);
            chk("t4_data", rdata, 16'h0080);
            chk("t4_id", {15'd0, rid}, 16'd1);
            step();
        end
        rr = 1'b1;
        #1;
        chk("t4_refill_ready0", {15'd0, r0}, 16'd1);
        step();
        chk("t4_refill_valid", {15'd0, rv}, 16'd1);
        chk("t4_refill_id", {15'd0, rid}, 16'd0);
        chk("t4_refill_data", rdata, 16'h0002);
        v0 = 1'b0; v1 = 1'b0;
        step();

        // 5: illegal select then legal clears err
        v0 = 1'b1; in0 = 16'h1234; sh0 = 4'd3; se0 = 2'b10;
        step();
        chk("t5_err", {15'd0, rerr}, 16'd1);
        chk("t5_data", rdata, 16'h0000);
        chk("t5_id", {15'd0, rid}, 16'd0);
        in0 = 16'h8001; sh0 = 4'd1; se0 = 2'b11;
        step();
        chk("t5_clr_err", {15'd0, rerr}, 16'd0);
        chk("t5_clr_data", rdata, 16'h0002);

        // 6: reset with a held response; port 0 was served last before reset
        v0 = 1'b0; rr = 1'b0;
        step();
        chk("t6_held", {15'd0, rv}, 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_valid", {15'd0, rv}, 16'd0);
        chk("t6_data", rdata, 16'h0000);
        chk("t6_err", {15'd0, rerr}, 16'd0);
        rr = 1'b1; v0 = 1'b1; v1 = 1'b1;
        in0 = 16'h00F0; sh0 = 4'd4; se0 = 2'b00;
        #1;
        chk("t6_ready0", {15'd0, r0}, 16'd1);
        chk("t6_ready1", {15'd0, r1}, 16'd0);
        step();
        chk("t6_id", {15'd0, rid}, 16'd0);
        chk("t6_res", rdata, 16'h000F);
        v0 = 1'b0; v1 = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
